seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the transmit end of the team's serial bit-sequence detectors.
- Loads a programmable LSB-aligned bit pattern and shifts it out MSB-first, one bit per clk.
- Supports a repeat count, an inter-frame gap, and abort.
- Drives test/stimulus streams into the 10011-style Mealy detectors and any other serial pattern consumer.

Parameters:
- W, 8, maximum pattern length in bits (W >= 2)
- CW, $clog2(W+1), width of the len port

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request to transmit; accepted only in IDLE
- pattern  input  W  bits to send, LSB-aligned; sent pattern[len-1] first, pattern[0] last
- len  input  CW  number of bits per frame; 0 or >W treated as W
- repeat_n  input  8  number of frames; 0 treated as 1
- gap  input  4  idle cycles between consecutive frames; 0 = back-to-back
- abort  input  1  synchronous cancel of the transfer in progress
- serial_out  output  1  transmitted bit; 0 whenever bit_valid=0
- bit_valid  output  1  serial_out carries a pattern bit this cycle
- frame_start  output  1  high with the first bit of every frame
- busy  output  1  transfer in progress (SEND or GAP)
- done  output  1  one-cycle pulse after the last bit of the last frame

Behaviour:
- Reset (async, any state): state=IDLE; serial_out, bit_valid, frame_start, busy, done all 0; internal shift register and counters cleared.
- All outputs are registered.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - All outputs 0.
  - start=1 and abort=0: latch pattern, clamped len, clamped repeat_n, and gap; next state SEND.
  - Latency: the first bit appears on serial_out the cycle after start is sampled.
- SEND:
  - bit_valid=1, busy=1, serial_out=current MSB of the latched frame.
  - frame_start=1 only on the first bit of each frame.
  - Bit counter runs 0..len-1.
  - On the last bit:
    - frames remaining >1 and gap=0: next state SEND, shift register reloaded; next frame's first bit follows with no bubble.
    - frames remaining >1 and gap>0: next state GAP.
    - Otherwise: next state DONE.
- GAP:
  - busy=1, bit_valid=0, serial_out=0.
  - Stays exactly gap cycles, then SEND with the frame reloaded.
- DONE:
  - done=1, busy=0, other outputs 0, for exactly one cycle.
  - Next state IDLE; start during DONE is ignored.
- start while busy or in DONE: ignored; latched values unchanged.
- Input changes: pattern/len/repeat_n/gap changes after acceptance have no effect on the current transfer.
- abort:
  - In SEND or GAP: next state IDLE, all outputs 0 next cycle, no done pulse.
  - In DONE: the done pulse still completes.
  - In IDLE: start ignored.
- Frame counter: 8-bit, decrements at the end of each frame; 255 frames supported with no wrap.
- len=1: each frame is one bit; with gap=0, frame_start is high every cycle.
- Reset mid-transfer: immediate return to IDLE per reset rule; no done pulse.

Test Plan:
- W=8, pattern=8'h13, len=5, repeat_n=1, gap=0, start pulse at cycle 0 -> serial_out 1,0,0,1,1 with bit_valid=1 in cycles 1-5; frame_start only at cycle 1; busy=1 cycles 1-5; done=1 at cycle 6 only.
- Same pattern, repeat_n=3, gap=0 -> 15 contiguous valid bits 100111001110011; frame_start at cycles 1, 6, 11; done at cycle 16; the team's overlapping 10011 Mealy detector on the loopback pulses 3 times.
- repeat_n=2, gap=2 -> bits in cycles 1-5, bit_valid=0 and busy=1 in cycles 6-7, bits in cycles 8-12, done at cycle 13.
- len=0, pattern=8'hA5, repeat_n=0 -> treated as len=8, one frame: 1,0,1,0,0,1,0,1 in cycles 1-8; done at cycle 9.
- abort at the 3rd bit of frame 1 (repeat_n=2) -> next cycle all outputs 0, no done pulse; a new start then transmits the full new frame.
- Async rst asserted mid-GAP, plus start re-pulsed while busy -> outputs 0 immediately on rst; the start issued while busy produced no extra frame or change to latched len.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx -- serial pattern transmitter.
//
// Loads an LSB-aligned pattern of len bits and shifts it out MSB-first, one
// bit per clk. It can repeat the frame repeat_n times, put gap idle cycles
// between frames, and be cancelled with abort. Every output is a flop. Each
// output is computed from the next-state values, so the first bit shows up
// the cycle after start is sampled.
//
// Ports:
//   clk, rst      clock (rising edge) / asynchronous active-high reset
//   start         transfer request, accepted only in IDLE (and not with abort)
//   pattern[W]    frame bits, pattern[len-1] sent first, pattern[0] last
//   len[CW]       bits per frame; 0 or >W means W
//   repeat_n[8]   frame count; 0 means 1
//   gap[4]        idle cycles between frames; 0 = back-to-back
//   abort         cancels a transfer in SEND/GAP, no done pulse
//   serial_out    transmitted bit (0 when bit_valid=0)
//   bit_valid     serial_out carries a pattern bit
//   frame_start   first bit of each frame
//   busy          SEND or GAP
//   done          one-cycle pulse after the last bit of the last frame
module seq_pattern_tx #(
    parameter int W  = 8,
    parameter int CW = $clog2(W+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [CW-1:0] len,
    input  logic [7:0]    repeat_n,
    input  logic [3:0]    gap,
    input  logic          abort,
    output logic          serial_out,
    output logic          bit_valid,
    output logic          frame_start,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t        state, state_d;
    logic [W-1:0]  sreg, sreg_d;      // live shift register, current bit at MSB
    logic [W-1:0]  frame_q, frame_d;  // latched frame, MSB-aligned, for reloads
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] bitcnt, bitcnt_d;
    logic [7:0]    frames, frames_d;  // frames still to send, including current
    logic [3:0]    gap_q, gap_d;
    logic [3:0]    gapcnt, gapcnt_d;

    logic [CW-1:0] len_eff;
    logic [W-1:0]  aligned;

    // Clamp len and move the pattern up so its first bit sits at the MSB.
    // The shift register then always sends from bit W-1, whatever len is.
    always_comb begin
        len_eff = ((len == '0) || (len > CW'(W))) ? CW'(W) : len;
        aligned = pattern << (CW'(W) - len_eff);
    end

    always_comb begin
        state_d  = state;
        sreg_d   = sreg;
        frame_d  = frame_q;
        len_d    = len_q;
        bitcnt_d = bitcnt;
        frames_d = frames;
        gap_d    = gap_q;
        gapcnt_d = gapcnt;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_d  = SEND;
                    sreg_d   = aligned;
                    frame_d  = aligned;
                    len_d    = len_eff;
                    bitcnt_d = '0;
                    frames_d = (repeat_n == 8'd0) ? 8'd1 : repeat_n;
                    gap_d    = gap;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bitcnt == len_q - CW'(1)) begin
                    if (frames > 8'd1) begin
                        frames_d = frames - 8'd1;
                        if (gap_q == 4'd0) begin
                            sreg_d   = frame_q;
                            bitcnt_d = '0;
                        end else begin
                            state_d  = GAP;
                            gapcnt_d = gap_q;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    sreg_d   = sreg << 1;
                    bitcnt_d = bitcnt + CW'(1);
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gapcnt == 4'd1) begin
                    state_d  = SEND;
                    sreg_d   = frame_q;
                    bitcnt_d = '0;
                end else begin
                    gapcnt_d = gapcnt - 4'd1;
                end
            end
            DONE: state_d = IDLE;  // abort and start cannot cut the done pulse
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sreg        <= '0;
            frame_q     <= '0;
            len_q       <= '0;
            bitcnt      <= '0;
            frames      <= '0;
            gap_q       <= '0;
            gapcnt      <= '0;
            serial_out  <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            sreg        <= sreg_d;
            frame_q     <= frame_d;
            len_q       <= len_d;
            bitcnt      <= bitcnt_d;
            frames      <= frames_d;
            gap_q       <= gap_d;
            gapcnt      <= gapcnt_d;
            // Outputs describe the cycle the FSM is entering.
            serial_out  <= (state_d == SEND) && sreg_d[W-1];
            bit_valid   <= (state_d == SEND);
            frame_start <= (state_d == SEND) && (bitcnt_d == '0);
            busy        <= (state_d == SEND) || (state_d == GAP);
            done        <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx. Holds a per-cycle queue of the output
// tuples the spec requires. The queue is built from the accepted request,
// cut short on abort and cleared on reset. The outputs are compared with it
// on every falling edge. Directed transfers also pin literal bit strings,
// frame_start/done cycles and a loopback 10011 detector count.
module tb_seq_pattern_tx;
    localparam int W  = 8;
    localparam int CW = $clog2(W+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  pattern = '0;
    logic [CW-1:0] len = '0;
    logic [7:0]    repeat_n = '0;
    logic [3:0]    gap = '0;
    logic          abort = 1'b0;
    logic          serial_out, bit_valid, frame_start, busy, done;

    int checks = 0;
    int errors = 0;

    seq_pattern_tx #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
        .repeat_n(repeat_n), .gap(gap), .abort(abort),
        .serial_out(serial_out), .bit_valid(bit_valid),
        .frame_start(frame_start), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each queue entry is {serial_out, bit_valid, frame_start, busy, done}.
    // q[0] is what the outputs must show after the latest rising edge.
    logic [4:0] q[$];
    logic [4:0] m_cur;
    bit         m_had;
    int         m_l, m_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            m_had = (q.size() != 0);
            m_cur = m_had ? q.pop_front() : 5'b0;
            if (m_had && m_cur[1] && abort) begin
                q.delete();
            end else if (!m_had && start && !abort) begin
                m_l = ((len == 0) || (len > W)) ? W : int'(len);
                m_r = (repeat_n == 0) ? 1 : int'(repeat_n);
                for (int f = 0; f < m_r; f++) begin
                    for (int b = m_l - 1; b >= 0; b--)
                        q.push_back({pattern[b], 1'b1, (b == m_l - 1), 1'b1, 1'b0});
                    if (f < m_r - 1)
                        for (int g = 0; g < int'(gap); g++) q.push_back(5'b00010);
                end
                q.push_back(5'b00001);
            end
        end
    end

    always @(negedge clk) begin
        check("cycle_outputs", {27'd0, serial_out, bit_valid, frame_start, busy, done},
              {27'd0, (q.size() != 0) ? q[0] : 5'b0});
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] bits, fsm, dm, bm;
    int nbits, fcnt, dcnt, dcyc, det;
    logic [4:0] hist;

    task automatic send(input logic [W-1:0] p, input logic [CW-1:0] l,
                        input logic [7:0] r, input logic [3:0] g, input logic ab);
        @(negedge clk);
        pattern = p; len = l; repeat_n = r; gap = g; start = 1'b1; abort = ab;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    // Called at the falling edge of cycle 1 (cycle 0 = the start edge).
    task automatic collect(input int ncyc, input int abort_at, input int restart_at, input int rst_at);
        bits = '0; fsm = '0; dm = '0; bm = '0; hist = '0;
        nbits = 0; fcnt = 0; dcnt = 0; dcyc = 0; det = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (bit_valid) begin
                bits = {bits[30:0], serial_out};
                hist = {hist[3:0], serial_out};
                nbits++;
                if (nbits >= 5 && hist == 5'b10011) det++;
            end
            if (frame_start) begin fcnt++; if (c < 32) fsm[c] = 1'b1; end
            if (done) begin dcnt++; dcyc = c; if (c < 32) dm[c] = 1'b1; end
            if (busy && c < 32) bm[c] = 1'b1;
            // Changing inputs after acceptance must not touch the transfer.
            if (c == 1) begin pattern = 8'h5A; len = 3; repeat_n = 7; gap = 1; end
            abort = (c == abort_at);
            start = (c == restart_at);
            if (c == restart_at) begin len = 2; pattern = 8'hFF; end
            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1 check("rst_async_outputs", {27'd0, serial_out, bit_valid, frame_start, busy, done}, 32'd0);
            end
            if (c == rst_at + 1) rst = 1'b0;
            @(negedge clk);
        end
        abort = 1'b0; start = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        check("reset_state", {27'd0, serial_out, bit_valid, frame_start, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // single frame 10011
        send(8'h13, 5, 1, 0, 1'b0);
        collect(10, 0, 0, 0);
        check("t1_bits", bits, 32'b10011);
        check("t1_fs", fsm, 32'h2);
        check("t1_busy", bm, 32'h3E);
        check("t1_done", dm, 32'h40);

        // three back-to-back frames, loopback detector
        send(8'h13, 5, 3, 0, 1'b0);
        collect(20, 0, 0, 0);
        check("t2_bits", bits, 32'b100111001110011);
        check("t2_nbits", nbits, 15);
        check("t2_fs", fsm, (32'd1 << 1) | (32'd1 << 6) | (32'd1 << 11));
        check("t2_done", dm, 32'd1 << 16);
        check("t2_det", det, 3);

        // two frames with gap 2
        send(8'h13, 5, 2, 2, 1'b0);
        collect(16, 0, 0, 0);
        check("t3_bits", bits, 32'b1001110011);
        check("t3_fs", fsm, (32'd1 << 1) | (32'd1 << 8));
        check("t3_busy", bm, 32'h1FFE);
        check("t3_done", dm, 32'd1 << 13);

        // len=0 and repeat_n=0 clamp
        send(8'hA5, 0, 0, 0, 1'b0);
        collect(12, 0, 0, 0);
        check("t4_bits", bits, 32'hA5);
        check("t4_nbits", nbits, 8);
        check("t4_done", dm, 32'd1 << 9);

        // abort on 3rd bit of frame 1, then a fresh transfer
        send(8'h13, 5, 2, 0, 1'b0);
        collect(10, 3, 0, 0);
        check("t5_bits", bits, 32'b100);
        check("t5_done", dcnt, 0);
        send(8'hC3, 8, 1, 0, 1'b0);
        collect(12, 0, 0, 0);
        check("t5_new_bits", bits, 32'hC3);
        check("t5_new_done", dm, 32'd1 << 9);

        // start together with abort in IDLE is ignored
        send(8'h13, 5, 1, 0, 1'b1);
        collect(6, 0, 0, 0);
        check("t6_nbits", nbits, 0);
        check("t6_done", dcnt, 0);

        // len=1, three frames, frame_start every cycle
        send(8'h01, 1, 3, 0, 1'b0);
        collect(6, 0, 0, 0);
        check("t7_bits", bits, 32'b111);
        check("t7_fs", fsm, 32'hE);
        check("t7_done", dm, 32'h10);

        // 255 frames of len 2, no counter wrap
        send(8'h02, 2, 8'd255, 0, 1'b0);
        collect(520, 0, 0, 0);
        check("t8_nbits", nbits, 510);
        check("t8_fcnt", fcnt, 255);
        check("t8_dcyc", dcyc, 511);
        check("t8_dcnt", dcnt, 1);

        // start while busy, then async reset in the middle of the gap
        send(8'h13, 5, 2, 3, 1'b0);
        collect(14, 0, 3, 7);
        check("t9_bits", bits, 32'b10011);
        check("t9_nbits", nbits, 5);
        check("t9_done", dcnt, 0);
        send(8'h13, 5, 1, 0, 1'b0);
        collect(8, 0, 0, 0);
        check("t9_after_bits", bits, 32'b10011);
        check("t9_after_done", dm, 32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
